// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : des_pkg
//  Brief    : DES key-schedule tables, state type and pass-plan helpers.
//  Revision : 1.0
// ============================================================================
package des_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  // Table entries use DES numbering: bit 1 is the MSB of the source word.
  localparam byte unsigned C_PC1 [56] = '{
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,  8'd58, 8'd50,
    8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35,
    8'd27, 8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
    8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7,  8'd62, 8'd54,
    8'd46, 8'd38, 8'd30, 8'd22, 8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37,
    8'd29, 8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4
  };

  localparam byte unsigned C_PC2 [48] = '{
    8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,  8'd3,  8'd28, 8'd15, 8'd6,
    8'd21, 8'd10, 8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,  8'd16, 8'd7,
    8'd27, 8'd20, 8'd13, 8'd2,  8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55,
    8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48, 8'd44, 8'd49, 8'd39, 8'd56,
    8'd34, 8'd53, 8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
  };

  localparam logic [1:0] C_SHIFTS [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] cd;
    cd = '0;
    for (int i = 0; i < 56; i++) begin
      cd[6'(55 - i)] = key[6'(64 - int'(C_PC1[i]))];
    end
    return cd;
  endfunction

  // Encrypt jobs walk keys 0,1,2; decrypt jobs walk 2,1,0. 2-key 3DES folds 2 onto 0.
  function automatic logic [1:0] pass_key_idx(input logic [1:0] pass, input logic dec,
                                               input int num_keys);
    logic [1:0] idx;
    idx = dec ? (2'd2 - pass) : pass;
    if (num_keys == 1) begin
      idx = 2'd0;
    end else if (num_keys == 2 && idx == 2'd2) begin
      idx = 2'd0;
    end
    return idx;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] s);
    case (s)
      2'd1:    rotl28 = {x[26:0], x[27]};
      2'd2:    rotl28 = {x[25:0], x[27:26]};
      default: rotl28 = x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] s);
    case (s)
      2'd1:    rotr28 = {x[0], x[27:1]};
      2'd2:    rotr28 = {x[1:0], x[27:2]};
      default: rotr28 = x;
    endcase
  endfunction

  function automatic logic [55:0] rotl_cd(input logic [55:0] cd, input logic [1:0] s);
    return {rotl28(cd[55:28], s), rotl28(cd[27:0], s)};
  endfunction

  function automatic logic [55:0] rotr_cd(input logic [55:0] cd, input logic [1:0] s);
    return {rotr28(cd[55:28], s), rotr28(cd[27:0], s)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/des_pc2.sv
`default_nettype none
// ============================================================================
//  Module   : des_pc2
//  Brief    : Combinational PC-2 compression of a 56-bit CD word to 48 bits.
//  Revision : 1.0
// ============================================================================
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] i_cd,
  output logic [47:0] o_rk
);

  for (genvar i = 0; i < 48; i++) begin : g_bit
    assign o_rk[47-i] = i_cd[56 - int'(C_PC2[i])];
  end

endmodule
`default_nettype wire

// File: rtl/des_key_sched.sv
`default_nettype none
// ============================================================================
//  Module   : des_key_sched
//  Brief    : Sequential DES/3DES key schedule streaming 48-bit round keys.
//  Revision : 1.0
// ============================================================================
module des_key_sched
  import des_pkg::*;
#(
  parameter int NUM_KEYS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  output logic                  key_ready,
  input  logic [64*NUM_KEYS-1:0] key_in,
  input  logic                  key_dec,
  output logic                  rk_valid,
  input  logic                  rk_ready,
  output logic [47:0]           rk_data,
  output logic [3:0]            rk_round,
  output logic [1:0]            rk_pass,
  output logic                  rk_pass_dec,
  output logic                  rk_last,
  output logic                  busy
);

  localparam int         NUM_PASSES  = (NUM_KEYS == 1) ? 1 : 3;
  localparam logic [1:0] C_LAST_PASS = 2'(NUM_PASSES - 1);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [64*NUM_KEYS-1:0]  r_keys;
  logic                    r_job_dec;
  logic                    r_pass_dec;
  logic [1:0]              r_pass;
  logic [3:0]              r_round;
  logic [55:0]             r_cd;

  logic                    w_accept;
  logic                    w_hs;
  logic                    w_round_last;
  logic                    w_last;
  logic [1:0]              w_shift;
  logic [55:0]             w_cd_rot;
  logic [55:0]             w_cd_pc2;
  logic [47:0]             w_rk;
  logic [1:0]              w_first_idx;
  logic [1:0]              w_next_idx;
  logic [63:0]             w_first_key;
  logic [63:0]             w_next_key;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    key_ready   = 1'b0;
    rk_valid    = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        key_ready = 1'b1;
        if (key_valid) w_state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        rk_valid = 1'b1;
        busy     = 1'b1;
        if (rk_ready && w_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_accept     = key_ready && key_valid;
  assign w_hs         = rk_valid && rk_ready;
  assign w_shift      = C_SHIFTS[r_round];
  assign w_cd_rot     = rotl_cd(r_cd, w_shift);
  // Decrypt passes emit straight from CD; rotation back happens on handshake.
  assign w_cd_pc2     = r_pass_dec ? r_cd : w_cd_rot;
  assign w_round_last = r_pass_dec ? (r_round == 4'd0) : (r_round == 4'd15);
  assign w_last       = w_round_last && (r_pass == C_LAST_PASS);
  assign w_first_idx  = pass_key_idx(2'd0, key_dec, NUM_KEYS);
  assign w_next_idx   = pass_key_idx(r_pass + 2'd1, r_job_dec, NUM_KEYS);

  always_comb begin
    w_first_key = '0;
    w_next_key  = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (2'(k) == w_first_idx) w_first_key = key_in[64*k +: 64];
      if (2'(k) == w_next_idx)  w_next_key  = r_keys[64*k +: 64];
    end
  end

  des_pc2 u_pc2 (
    .i_cd (w_cd_pc2),
    .o_rk (w_rk)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_keys     <= '0;
      r_job_dec  <= 1'b0;
      r_pass_dec <= 1'b0;
      r_pass     <= 2'd0;
      r_round    <= 4'd0;
      r_cd       <= '0;
    end else if (w_accept) begin
      r_keys     <= key_in;
      r_job_dec  <= key_dec;
      r_pass_dec <= key_dec;
      r_pass     <= 2'd0;
      r_round    <= key_dec ? 4'd15 : 4'd0;
      r_cd       <= pc1(w_first_key);
    end else if (w_hs && !w_last) begin
      if (w_round_last) begin
        // Next pass runs the opposite direction, so it starts at the other end.
        r_pass     <= r_pass + 2'd1;
        r_pass_dec <= ~r_pass_dec;
        r_round    <= r_pass_dec ? 4'd0 : 4'd15;
        r_cd       <= pc1(w_next_key);
      end else if (r_pass_dec) begin
        r_cd    <= rotr_cd(r_cd, w_shift);
        r_round <= r_round - 4'd1;
      end else begin
        r_cd    <= w_cd_rot;
        r_round <= r_round + 4'd1;
      end
    end
  end

  assign rk_data     = rk_valid ? w_rk : 48'd0;
  assign rk_last     = rk_valid && w_last;
  assign rk_round    = r_round;
  assign rk_pass     = r_pass;
  assign rk_pass_dec = r_pass_dec;

endmodule
`default_nettype wire

// File: tb/tb_des_key_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_des_key_sched
//  Brief    : Self-checking bench for des_key_sched (1, 2 and 3 key builds).
//  Revision : 1.0
// ============================================================================
module tb_des_key_sched;

  typedef struct packed {
    logic [47:0] data;
    logic [3:0]  round;
    logic [1:0]  pass;
    logic        pdec;
    logic        last;
  } rk_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_valid = 1'b0;
  logic         key_dec = 1'b0;
  logic         rk_ready = 1'b0;
  logic [191:0] key_bus = '0;
  int           sel = 1;

  logic         kv [1:3];
  logic         kr [1:3];
  logic         rv [1:3];
  logic [47:0]  rd [1:3];
  logic [3:0]   rr [1:3];
  logic [1:0]   rp [1:3];
  logic         rpd [1:3];
  logic         rl [1:3];
  logic         bz [1:3];

  logic         m_ready, m_valid, m_pdec, m_last, m_busy;
  logic [47:0]  m_data;
  logic [3:0]   m_round;
  logic [1:0]   m_pass;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign kv[1] = key_valid && (sel == 1);
  assign kv[2] = key_valid && (sel == 2);
  assign kv[3] = key_valid && (sel == 3);

  des_key_sched #(.NUM_KEYS(1)) u_dut1 (
    .clk(clk), .rst(rst), .key_valid(kv[1]), .key_ready(kr[1]),
    .key_in(key_bus[63:0]), .key_dec(key_dec), .rk_valid(rv[1]), .rk_ready(rk_ready),
    .rk_data(rd[1]), .rk_round(rr[1]), .rk_pass(rp[1]), .rk_pass_dec(rpd[1]),
    .rk_last(rl[1]), .busy(bz[1])
  );

  des_key_sched #(.NUM_KEYS(2)) u_dut2 (
    .clk(clk), .rst(rst), .key_valid(kv[2]), .key_ready(kr[2]),
    .key_in(key_bus[127:0]), .key_dec(key_dec), .rk_valid(rv[2]), .rk_ready(rk_ready),
    .rk_data(rd[2]), .rk_round(rr[2]), .rk_pass(rp[2]), .rk_pass_dec(rpd[2]),
    .rk_last(rl[2]), .busy(bz[2])
  );

  des_key_sched #(.NUM_KEYS(3)) u_dut3 (
    .clk(clk), .rst(rst), .key_valid(kv[3]), .key_ready(kr[3]),
    .key_in(key_bus), .key_dec(key_dec), .rk_valid(rv[3]), .rk_ready(rk_ready),
    .rk_data(rd[3]), .rk_round(rr[3]), .rk_pass(rp[3]), .rk_pass_dec(rpd[3]),
    .rk_last(rl[3]), .busy(bz[3])
  );

  always_comb begin
    int si;
    si      = (sel >= 1 && sel <= 3) ? sel : 1;
    m_ready = kr[si];
    m_valid = rv[si];
    m_data  = rd[si];
    m_round = rr[si];
    m_pass  = rp[si];
    m_pdec  = rpd[si];
    m_last  = rl[si];
    m_busy  = bz[si];
  end

  // Reference tables in DES bit numbering.
  int pc1_t [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                     60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                     29,21,13,5,28,20,12,4};
  int pc2_t [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int sh_t  [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  logic [47:0] sk [16];
  rk_t         exp_q [$];

  logic [47:0] first_data, last_data;
  logic [3:0]  first_round, last_round;
  logic [1:0]  pass_rec [3];
  logic        pdec_rec [3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Subkey i uses the cumulative rotation of C and D, taken modulo 28.
  task automatic compute_subkeys(input logic [63:0] key);
    bit b [65];
    bit c [28];
    bit d [28];
    bit cd2 [56];
    logic [47:0] v;
    int tot;
    for (int n = 1; n <= 64; n++) b[n] = key[64-n];
    for (int j = 0; j < 28; j++) begin
      c[j] = b[pc1_t[j]];
      d[j] = b[pc1_t[28+j]];
    end
    tot = 0;
    for (int i = 0; i < 16; i++) begin
      tot += sh_t[i];
      for (int j = 0; j < 28; j++) begin
        cd2[j]    = c[(j + tot) % 28];
        cd2[28+j] = d[(j + tot) % 28];
      end
      for (int j = 0; j < 48; j++) v[47-j] = cd2[pc2_t[j]-1];
      sk[i] = v;
    end
  endtask

  task automatic build_expected(input int nk, input logic [191:0] keys, input bit dec);
    int np;
    np = (nk == 1) ? 1 : 3;
    exp_q.delete();
    for (int p = 0; p < np; p++) begin
      int idx;
      bit pd;
      rk_t e;
      idx = dec ? 2 - p : p;
      if (nk == 1) idx = 0;
      else if (nk == 2 && idx == 2) idx = 0;
      pd = (nk == 1) ? dec : (dec ? (p != 1) : (p == 1));
      compute_subkeys(keys[64*idx +: 64]);
      for (int r = 0; r < 16; r++) begin
        int k;
        k       = pd ? 15 - r : r;
        e.data  = sk[k];
        e.round = 4'(k);
        e.pass  = 2'(p);
        e.pdec  = pd;
        e.last  = (p == np - 1) && (r == 15);
        exp_q.push_back(e);
      end
    end
  endtask

  function automatic logic [191:0] rand_keys();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_job(input int s, input logic [191:0] keys, input bit dec,
                         input bit bp, input bit pulse, input int abort_at);
    int  n_exp, hs, cyc, w, budget;
    bit  stalled, r;
    rk_t obs, prev, e;
    sel = s;
    #1;
    build_expected(s, keys, dec);
    n_exp  = exp_q.size();
    budget = 8 * n_exp + 100;
    w = 0;
    while (!m_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!m_ready) chk("wait_ready", 64'(m_ready), 64'd1);
    key_bus   = keys;
    key_dec   = dec;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    chk("first_valid", 64'(m_valid), 64'd1);
    hs = 0; cyc = 0; stalled = 0; prev = '0;
    while (hs < n_exp) begin
      obs = '{m_data, m_round, m_pass, m_pdec, m_last};
      chk("rk_valid", 64'(m_valid), 64'd1);
      chk("busy_ready", 64'({m_busy, m_ready}), 64'd2);
      if (stalled) chk("stall_hold", 64'(obs), 64'(prev));
      r         = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      rk_ready  = r;
      key_valid = pulse && ($urandom_range(0, 3) == 0);
      if (key_valid) begin
        key_bus = rand_keys();
        key_dec = 1'($urandom);
      end
      if (m_valid && r) begin
        e = exp_q.pop_front();
        chk("rk", 64'(obs), 64'(e));
        if (hs == 0) begin
          first_data  = obs.data;
          first_round = obs.round;
        end
        if (hs % 16 == 0 && hs / 16 < 3) begin
          pass_rec[hs/16] = obs.pass;
          pdec_rec[hs/16] = obs.pdec;
        end
        last_data  = obs.data;
        last_round = obs.round;
        hs++;
      end
      stalled = m_valid && !r;
      prev    = obs;
      cyc++;
      if (cyc > budget) begin
        chk("timeout", 64'(cyc), 64'(budget));
        break;
      end
      if (abort_at > 0 && hs == abort_at) begin
        @(negedge clk);
        key_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        chk("mid_rst", 64'({m_ready, m_valid, m_busy, m_last}), 64'h8);
        rst = 1'b0;
        exp_q.delete();
        return;
      end
      @(negedge clk);
    end
    key_valid = 1'b0;
    chk("idle_after", 64'({m_ready, m_valid, m_busy}), 64'h4);
    if (!bp) chk("valid_cycles", 64'(cyc), 64'(n_exp));
  endtask

  initial begin
    logic [191:0] kv_std;
    kv_std = {128'd0, 64'h133457799BBCDFF1};

    repeat (3) @(negedge clk);
    for (int s = 1; s <= 3; s++) begin
      sel = s;
      #1;
      chk("reset", 64'({m_ready, m_valid, m_last, m_busy, m_data, m_round, m_pass, m_pdec}),
          64'({4'b1000, 55'd0}));
    end
    rst = 1'b0;
    @(negedge clk);

    run_job(1, kv_std, 1'b0, 1'b0, 1'b0, 0);
    chk("des_enc_k1", 64'(first_data), 64'h1B02EFFC7072);
    chk("des_enc_k16", 64'(last_data), 64'hCB3D8B0E17F5);

    run_job(1, kv_std, 1'b1, 1'b0, 1'b0, 0);
    chk("des_dec_first", 64'({first_round, first_data}), 64'({4'd15, 48'hCB3D8B0E17F5}));
    chk("des_dec_last", 64'({last_round, last_data}), 64'({4'd0, 48'h1B02EFFC7072}));

    run_job(3, rand_keys(), 1'b0, 1'b0, 1'b0, 0);
    chk("tdes3_passes", 64'({pass_rec[0], pass_rec[1], pass_rec[2]}), 64'b00_01_10);
    chk("tdes3_pdec", 64'({pdec_rec[0], pdec_rec[1], pdec_rec[2]}), 64'b010);

    for (int j = 0; j < 6; j++) begin
      run_job(int'($urandom_range(1, 3)), rand_keys(), 1'($urandom), 1'b1, 1'b1, 0);
    end

    run_job(3, rand_keys(), 1'b0, 1'b1, 1'b0, 7);
    run_job(3, rand_keys(), 1'b0, 1'b0, 1'b0, 0);

    run_job(2, rand_keys(), 1'b1, 1'b0, 1'b0, 0);
    chk("tdes2_pdec", 64'({pdec_rec[0], pdec_rec[1], pdec_rec[2]}), 64'b101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
